// File: rtl/pipe_drain_fifo.sv
// rtl/pipe_drain_fifo.sv - credit-gated receive buffer behind a fixed-latency, non-stallable pipe
// Credits cover stored words plus words still in flight, so an arrival always has room.
module pipe_drain_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic                         issueOk,
   input  logic                         issue,
   input  logic                         dataInValid,
   input  logic [WIDTH-1:0]             dataIn,
   output logic [WIDTH-1:0]             dataOut,
   output logic                         dataOutValid,
   input  logic                         dataOutReady,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         issueViolation
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [CW-1:0]    credits_q, credits_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic             issue_viol_q, issue_viol_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic issue_acc;
   logic pop;
   logic push;

   assign issueOk        = (credits_q != '0);
   assign dataOutValid   = (count_q != '0);
   assign dataOut        = mem_q[rd_ptr_q];
   assign count          = count_q;
   assign overflow       = overflow_q;
   assign issueViolation = issue_viol_q;

   // A pop in the same cycle frees the slot the arriving word needs.
   always_comb begin
      issue_acc    = issue & issueOk;
      pop          = dataOutValid & dataOutReady;
      push         = dataInValid & ((count_q != DEPTH_C) | pop);
      credits_d    = credits_q - {{(CW-1){1'b0}}, issue_acc} + {{(CW-1){1'b0}}, pop};
      count_d      = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      overflow_d   = overflow_q | (dataInValid & ~push);
      issue_viol_d = issue_viol_q | (issue & ~issueOk);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits_q    <= DEPTH_C;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         issue_viol_q <= 1'b0;
      end else begin
         credits_q    <= credits_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
         issue_viol_q <= issue_viol_d;
      end
   end

   // Storage contents need no reset; count and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= dataIn;
      end
   end

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// tb/tb_pipe_drain_fifo.sv - randomized bench for pipe_drain_fifo with a queue-based reference model
module tb_pipe_drain_fifo;

   localparam int DEPTH = 16;
   localparam int LAT   = 4;

   logic       clk;
   logic       rst_n;
   logic       issueOk;
   logic       issue;
   logic       dataInValid;
   logic [7:0] dataIn;
   logic [7:0] dataOut;
   logic       dataOutValid;
   logic       dataOutReady;
   logic [4:0] count;
   logic       overflow;
   logic       issueViolation;

   pipe_drain_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .issueOk        (issueOk),
      .issue          (issue),
      .dataInValid    (dataInValid),
      .dataIn         (dataIn),
      .dataOut        (dataOut),
      .dataOutValid   (dataOutValid),
      .dataOutReady   (dataOutReady),
      .count          (count),
      .overflow       (overflow),
      .issueViolation (issueViolation)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks;
   int         n_err;
   logic [7:0] q[$];
   int         m_credits;
   logic       m_ovf;
   logic       m_iv;
   logic       pv [1:LAT];
   logic [7:0] pd [1:LAT];
   logic [7:0] next_word;
   int         acc_cnt;
   int         n_pops;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("issueOk", int'(issueOk), int'(m_credits != 0));
      chk("dataOutValid", int'(dataOutValid), int'(q.size() != 0));
      chk("count", int'(count), q.size());
      if (q.size() != 0) chk("dataOut", int'(dataOut), int'(q[0]));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("issueViolation", int'(issueViolation), int'(m_iv));
   endtask

   task automatic model_reset();
      q.delete();
      m_credits = DEPTH;
      m_ovf     = 1'b0;
      m_iv      = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         pv[k] = 1'b0;
         pd[k] = 8'h00;
      end
   endtask

   // One clock: drive inputs at the falling edge, advance the model, check after the edge.
   task automatic cycle_in(input logic iss, input logic rdy, input logic fv, input logic [7:0] fd);
      logic m_pop;
      logic acc;
      logic pok;
      issue        = iss;
      dataOutReady = rdy;
      dataInValid  = pv[LAT] | fv;
      dataIn       = fv ? fd : pd[LAT];
      m_pop = (q.size() != 0) && rdy;
      acc   = iss && (m_credits != 0);
      if (iss && m_credits == 0) m_iv = 1'b1;
      pok = dataInValid && ((q.size() < DEPTH) || m_pop);
      if (dataInValid && !pok) m_ovf = 1'b1;
      if (m_pop) begin
         void'(q.pop_front());
         n_pops++;
      end
      if (pok) q.push_back(dataIn);
      m_credits = m_credits - int'(acc) + int'(m_pop);
      if (acc) acc_cnt++;
      @(posedge clk);
      for (int k = LAT; k >= 2; k--) begin
         pv[k] = pv[k-1];
         pd[k] = pd[k-1];
      end
      pv[1] = acc;
      pd[1] = next_word;
      if (acc) next_word = next_word + 8'd1;
      @(negedge clk);
      check_all();
   endtask

   // mode 0 idle, 1 fill, 2 drain, 3 steady, 4 random, 5 issue at most 9 words with consumer stalled
   task automatic run(input int n, input int mode);
      logic iss;
      logic rdy;
      for (int i = 0; i < n; i++) begin
         iss = 1'b0;
         rdy = 1'b0;
         case (mode)
            1: iss = (m_credits != 0);
            2: rdy = 1'b1;
            3: begin iss = (m_credits != 0); rdy = 1'b1; end
            4: begin
               iss = ($urandom_range(0, 3) != 0) && (m_credits != 0);
               rdy = ($urandom_range(0, 2) != 0);
            end
            5: iss = (m_credits != 0) && (acc_cnt < 9);
            default: ;
         endcase
         cycle_in(iss, rdy, 1'b0, 8'h00);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_err        = 0;
      next_word    = 8'h00;
      acc_cnt      = 0;
      n_pops       = 0;
      rst_n        = 1'b0;
      issue        = 1'b0;
      dataInValid  = 1'b0;
      dataIn       = 8'h00;
      dataOutReady = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_all();
      chk("reset_issueOk", int'(issueOk), 1);
      chk("reset_count", int'(count), 0);
      chk("reset_valid", int'(dataOutValid), 0);

      acc_cnt = 0;
      run(30, 1);
      chk("fill_issues", acc_cnt, 16);
      chk("fill_count", int'(count), 16);
      chk("fill_issueOk", int'(issueOk), 0);
      chk("fill_overflow", int'(overflow), 0);
      chk("fill_head", int'(dataOut), 8'h00);

      cycle_in(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_issueOk_rise", int'(issueOk), 1);
      chk("drain_second_word", int'(dataOut), 8'h01);
      run(15, 2);
      chk("drain_empty", int'(count), 0);

      n_pops = 0;
      run(120, 3);
      chk("steady_count", int'(count), 1);
      chk("steady_issueOk", int'(issueOk), 1);
      chk("steady_delivered", int'(n_pops >= 100), 1);

      run(1500, 4);
      run(30, 2);
      chk("random_drained", int'(count), 0);

      acc_cnt = 0;
      run(20, 5);
      chk("pre_reset_count", int'(count), 9);
      chk("pre_reset_issueOk", int'(issueOk), 1);
      #2;
      rst_n        = 1'b0;
      issue        = 1'b0;
      dataInValid  = 1'b0;
      dataOutReady = 1'b0;
      #1;
      chk("async_reset_issueOk", int'(issueOk), 1);
      chk("async_reset_count", int'(count), 0);
      chk("async_reset_valid", int'(dataOutValid), 0);
      chk("async_reset_overflow", int'(overflow), 0);
      chk("async_reset_viol", int'(issueViolation), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      check_all();

      run(30, 1);
      chk("refill_count", int'(count), 16);
      chk("refill_issueOk", int'(issueOk), 0);
      cycle_in(1'b1, 1'b0, 1'b0, 8'h00);
      chk("viol_flag", int'(issueViolation), 1);
      chk("viol_issueOk", int'(issueOk), 0);
      chk("viol_count", int'(count), 16);
      cycle_in(1'b0, 1'b1, 1'b1, 8'hA5);
      chk("full_pushpop_count", int'(count), 16);
      chk("full_pushpop_ovf", int'(overflow), 0);
      cycle_in(1'b0, 1'b0, 1'b1, 8'h5A);
      chk("overflow_flag", int'(overflow), 1);
      chk("overflow_count", int'(count), 16);
      run(20, 2);
      chk("final_empty", int'(count), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
